// File: rtl/tmds_decoder_if.sv
// Symbol/pixel bus between a TMDS deserializer and the decoder.
// master = deserializer side, slave = decoder side.
interface tmds_decoder_if;
    logic [9:0] symbol_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       valid_out;
    logic       locked_out;
    logic       bitslip_out;

    modport master (
        output symbol_in, valid_in,
        input  data_out, ctrl_out, de_out, valid_out, locked_out, bitslip_out
    );

    modport slave (
        input  symbol_in, valid_in,
        output data_out, ctrl_out, de_out, valid_out, locked_out, bitslip_out
    );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS 10b->8b decoder with word-alignment FSM: locks on a run of control
// tokens, requests bit-slips while searching, drops lock on a long token drought.
module tmds_decoder #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_WAIT      = 16,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic          clk_in,
    input  logic          rst_in,
    tmds_decoder_if.slave bus
);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_SLIP_WAIT, ST_LOCKED} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] run_cnt, run_nxt;
    logic [SW-1:0] srch_cnt, srch_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [LW-1:0] loss_cnt, loss_nxt;
    logic          slip_nxt, vld_nxt, is_ctrl;

    logic [7:0]    data_p1;
    logic [1:0]    ctrl_p1;
    logic          de_p1, vld_p1, locked_p1, slip_p1;

    function automatic logic ctrl_match(input logic [9:0] s);
        return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
    endfunction

    function automatic logic [1:0] ctrl_code(input logic [9:0] s);
        case (s)
            10'h0AB: return 2'b01;
            10'h154: return 2'b10;
            10'h2AB: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    function automatic logic [7:0] decode_data(input logic [9:0] s);
        logic [7:0] d, q;
        d    = s[9] ? ~s[7:0] : s[7:0];
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return q;
    endfunction

    assign is_ctrl = ctrl_match(bus.symbol_in);

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        srch_nxt  = srch_cnt;
        wait_nxt  = wait_cnt;
        loss_nxt  = loss_cnt;
        slip_nxt  = 1'b0;
        vld_nxt   = 1'b0;
        case (state)
            ST_SEARCH: if (bus.valid_in) begin
                run_nxt  = is_ctrl ? run_cnt + RW'(1) : '0;
                srch_nxt = srch_cnt + SW'(1);
                // Lock wins over a simultaneous timeout.
                if (run_nxt == RW'(LOCK_COUNT)) begin
                    state_nxt = ST_LOCKED;
                    vld_nxt   = 1'b1;
                    run_nxt   = '0;
                    srch_nxt  = '0;
                end else if (srch_nxt == SW'(SEARCH_TIMEOUT)) begin
                    state_nxt = ST_SLIP_WAIT;
                    slip_nxt  = 1'b1;
                    run_nxt   = '0;
                    srch_nxt  = '0;
                end
            end
            ST_SLIP_WAIT: begin
                wait_nxt = wait_cnt + WW'(1);
                if (wait_nxt == WW'(SLIP_WAIT)) begin
                    state_nxt = ST_SEARCH;
                    wait_nxt  = '0;
                end
            end
            ST_LOCKED: if (bus.valid_in) begin
                vld_nxt  = 1'b1;
                loss_nxt = is_ctrl ? '0 : loss_cnt + LW'(1);
                if (loss_nxt == LW'(LOSS_TIMEOUT)) begin
                    state_nxt = ST_SEARCH;
                    loss_nxt  = '0;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_SEARCH;
            run_cnt  <= '0;
            srch_cnt <= '0;
            wait_cnt <= '0;
            loss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            srch_cnt <= srch_nxt;
            wait_cnt <= wait_nxt;
            loss_cnt <= loss_nxt;
        end
    end

    // p1: registered decoder outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_p1   <= '0;
            ctrl_p1   <= '0;
            de_p1     <= 1'b0;
            vld_p1    <= 1'b0;
            locked_p1 <= 1'b0;
            slip_p1   <= 1'b0;
        end else begin
            vld_p1    <= vld_nxt;
            locked_p1 <= (state_nxt == ST_LOCKED);
            slip_p1   <= slip_nxt;
            if (bus.valid_in) begin
                de_p1   <= ~is_ctrl;
                data_p1 <= is_ctrl ? 8'h00 : decode_data(bus.symbol_in);
                if (is_ctrl)
                    ctrl_p1 <= ctrl_code(bus.symbol_in);
            end
        end
    end

    assign bus.data_out    = data_p1;
    assign bus.ctrl_out    = ctrl_p1;
    assign bus.de_out      = de_p1;
    assign bus.valid_out   = vld_p1;
    assign bus.locked_out  = locked_p1;
    assign bus.bitslip_out = slip_p1;
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, lock, decode, broken run,
// bit-slip timing, loss of lock and asynchronous reset.
module tb_tmds_decoder;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   total = 0;
    int   bad   = 0;

    tmds_decoder_if bus();

    tmds_decoder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [9:0] s);
        bus.symbol_in = s;
        bus.valid_in  = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.valid_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        bus.valid_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic lock_354();
        for (int i = 0; i < 8; i++) put(10'h354);
    endtask

    int slips;

    initial begin
        bus.symbol_in = '0;
        bus.valid_in  = 1'b0;
        #1;
        chk("rst_data",   bus.data_out,    8'h00);
        chk("rst_ctrl",   bus.ctrl_out,    2'b00);
        chk("rst_de",     bus.de_out,      1'b0);
        chk("rst_valid",  bus.valid_out,   1'b0);
        chk("rst_locked", bus.locked_out,  1'b0);
        chk("rst_slip",   bus.bitslip_out, 1'b0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Lock on eight 0x354 tokens
        for (int i = 0; i < 7; i++) put(10'h354);
        chk("lock_early",  bus.locked_out, 1'b0);
        chk("search_vld",  bus.valid_out,  1'b0);
        put(10'h354);
        chk("lock_locked", bus.locked_out, 1'b1);
        chk("lock_valid",  bus.valid_out,  1'b1);
        chk("lock_de",     bus.de_out,     1'b0);
        chk("lock_ctrl",   bus.ctrl_out,   2'b00);

        // Data decode while locked
        put(10'h100);
        chk("dec100_data", bus.data_out, 8'h00);
        chk("dec100_de",   bus.de_out,   1'b1);
        chk("dec100_vld",  bus.valid_out, 1'b1);
        chk("dec100_ctrl", bus.ctrl_out, 2'b00);
        put(10'h1F0);
        chk("dec1F0_data", bus.data_out, 8'h10);
        put(10'h2F0);
        chk("dec2F0_data", bus.data_out, 8'hEF);
        put(10'h200);
        chk("dec200_data", bus.data_out, 8'hFF);
        chk("dec200_de",   bus.de_out,   1'b1);
        idle();
        chk("hold_vld",  bus.valid_out, 1'b0);
        chk("hold_data", bus.data_out,  8'hFF);
        chk("hold_de",   bus.de_out,    1'b1);
        put(10'h2AB);
        chk("tok2AB_ctrl", bus.ctrl_out, 2'b11);
        chk("tok2AB_data", bus.data_out, 8'h00);
        chk("tok2AB_de",   bus.de_out,   1'b0);

        // Asynchronous reset between edges while locked
        put(10'h100);
        chk("pre_arst_vld", bus.valid_out, 1'b1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_locked", bus.locked_out, 1'b0);
        chk("arst_vld",    bus.valid_out,  1'b0);
        chk("arst_data",   bus.data_out,   8'h00);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        for (int i = 0; i < 7; i++) put(10'h354);
        chk("relock_early", bus.locked_out, 1'b0);
        put(10'h354);
        chk("relock", bus.locked_out, 1'b1);

        // Broken run: 7 x 0x0AB, a data symbol, then 8 x 0x154
        do_reset();
        for (int i = 0; i < 7; i++) put(10'h0AB);
        put(10'h100);
        chk("brk_after_data", bus.locked_out, 1'b0);
        for (int i = 0; i < 7; i++) put(10'h154);
        chk("brk_early", bus.locked_out, 1'b0);
        put(10'h154);
        chk("brk_locked", bus.locked_out, 1'b1);
        chk("brk_ctrl",   bus.ctrl_out,   2'b10);

        // Bit-slip after 1024 symbols, then 16 ignored cycles, then count restarts
        do_reset();
        slips = 0;
        for (int i = 0; i < 1023; i++) begin
            put(10'h100);
            if (bus.bitslip_out) slips++;
        end
        chk("slip_none_before", slips, 0);
        put(10'h100);
        chk("slip_pulse",  bus.bitslip_out, 1'b1);
        chk("slip_unlock", bus.locked_out,  1'b0);
        slips = 0;
        for (int i = 0; i < 16; i++) begin
            put(10'h100);
            if (bus.bitslip_out) slips++;
        end
        chk("slip_wait_quiet", slips, 0);
        slips = 0;
        for (int i = 0; i < 1023; i++) begin
            put(10'h100);
            if (bus.bitslip_out) slips++;
        end
        chk("slip_restart_quiet", slips, 0);
        put(10'h100);
        chk("slip_second", bus.bitslip_out, 1'b1);
        idle();
        chk("slip_one_cycle", bus.bitslip_out, 1'b0);

        // Loss of lock after 65536 data symbols without a token
        do_reset();
        lock_354();
        chk("loss_locked", bus.locked_out, 1'b1);
        slips = 0;
        for (int i = 0; i < 65535; i++) begin
            put(10'h100);
            if (!bus.locked_out) slips++;
        end
        chk("loss_held", slips, 0);
        put(10'h100);
        chk("loss_dropped", bus.locked_out, 1'b0);
        chk("loss_last_vld", bus.valid_out, 1'b1);
        put(10'h100);
        chk("loss_vld_off", bus.valid_out, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 8: consecutive control tokens required to declare lock.
REQ-002 Parameter SEARCH_TIMEOUT, default 1024: valid symbols without a lock before a bit-slip is requested.
REQ-003 Parameter SLIP_WAIT, default 16: clock cycles ignored after each bit-slip request.
REQ-004 Parameter LOSS_TIMEOUT, default 65536: valid symbols without any control token before lock is dropped.
REQ-005 clk_in  input  1  single clock; all logic is on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous and active-high.
REQ-007 symbol_in  input  10  received TMDS symbol, bit 0 first on the wire.
REQ-008 valid_in  input  1  symbol_in qualifier, one symbol per high cycle.
REQ-009 data_out  output  8  decoded pixel byte.
REQ-010 ctrl_out  output  2  {C1,C0} of the last control token.
REQ-011 de_out  output  1  1 = data symbol, 0 = control token.
REQ-012 valid_out  output  1  data_out/de_out qualifier.
REQ-013 locked_out  output  1  word alignment established.
REQ-014 bitslip_out  output  1  one-cycle request to the deserializer to shift word boundary by one bit.

Function
REQ-015 Control tokens SHALL be exact matches: 0x354 -> 00, 0x0AB -> 01, 0x154 -> 10, 0x2AB -> 11; no other value is a control token.
REQ-016 Data decode SHALL proceed as follows: d = symbol[9] ? ~symbol[7:0] : symbol[7:0]; data_out[0] = d[0]; for i = 1..7, data_out[i] = d[i]^d[i-1] if symbol[8] = 1, else ~(d[i]^d[i-1]).
REQ-017 Outputs SHALL be registered, with a latency of 1 cycle from a valid_in cycle to the matching valid_out cycle.
REQ-018 valid_out SHALL be 1 only in the cycle after a valid_in = 1 cycle in which the FSM was LOCKED, or in which the lock was just achieved by that symbol.
REQ-019 On a control token: de_out = 0, ctrl_out updated, data_out = 0x00.
REQ-020 On a data symbol: de_out = 1, data_out decoded, ctrl_out holds its previous value.
REQ-021 Output registers SHALL hold their values in cycles where valid_in = 0.
REQ-022 The FSM SHALL have the states SEARCH, SLIP_WAIT and LOCKED.
REQ-023 SEARCH SHALL operate as follows:
- A valid control token increments run_cnt; a valid data symbol clears run_cnt.
- Every valid symbol increments srch_cnt.
REQ-024 In SEARCH, when run_cnt reaches LOCK_COUNT, the FSM SHALL go to LOCKED, set locked_out = 1 on the next cycle, and clear all counters.
REQ-025 In SEARCH, when srch_cnt reaches SEARCH_TIMEOUT without a lock:
- bitslip_out pulses high for exactly 1 cycle;
- the FSM enters SLIP_WAIT and clears run_cnt and srch_cnt.
REQ-026 If the lock condition (REQ-024) and the timeout (REQ-025) fall on the same symbol, the lock SHALL take priority and no bit-slip is issued.
REQ-027 SLIP_WAIT SHALL count SLIP_WAIT clock cycles regardless of valid_in, ignore all symbols, then return to SEARCH.
REQ-028 LOCKED SHALL operate as follows:
- A valid control token clears loss_cnt; a valid data symbol increments loss_cnt.
- When loss_cnt reaches LOSS_TIMEOUT, the FSM goes to SEARCH, locked_out drops the next cycle, and the counters clear.
REQ-029 No counter SHALL wrap around; each saturates at its threshold until its state transition occurs.
REQ-030 bitslip_out SHALL never be high for two consecutive cycles and SHALL never be high while locked_out = 1.

Reset
REQ-031 While rst_in = 1, the outputs SHALL immediately take these values:
- data_out = 0x00, ctrl_out = 00, de_out = 0;
- valid_out = 0, locked_out = 0, bitslip_out = 0.
REQ-032 While rst_in = 1, the FSM SHALL be in SEARCH with all counters zero.
REQ-033 Reset asserted mid-operation, in any state, SHALL abandon lock, any pending slip and the wait count; after release, operation restarts from SEARCH.

Verification
REQ-034 Lock: 8 valid 0x354 symbols -> locked_out = 1 the cycle after the 8th; valid_out = 1 with de_out = 0, ctrl_out = 00.
REQ-035 Data decode when locked: 0x100 -> data_out 0x00; 0x200 -> data_out 0xFF; de_out = 1; ctrl_out unchanged.
REQ-036 Slip: 1024 valid data symbols (e.g. 0x100) from reset -> bitslip_out high for one cycle; no further slip request for the next 16 cycles; srch_cnt restarts from 0.
REQ-037 Broken run: 7 × 0x0AB, one 0x100, then 8 × 0x154 -> lock only after the final 0x154; ctrl_out = 10.
REQ-038 Loss of lock: while LOCKED, 65536 valid data symbols with no control token -> locked_out = 0 on the next cycle and valid_out = 0 thereafter.
REQ-039 Asynchronous reset: assert rst_in mid-stream between clock edges while LOCKED -> locked_out and valid_out go to 0 without waiting for a clock edge; after release, a full LOCK_COUNT run is required to relock.
